// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style front end.
//   OP_RTYPE          : opcode of register-format instructions
//   NOP_WORD_DEFAULT  : instruction word used for a pipeline bubble
//   *_MSB / *_LSB     : instruction field bit positions
//   fetch_state_t     : fetch controller state encoding (2-bit)
package mips_pkg;

  localparam logic [5:0]  OP_RTYPE         = 6'h00;
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  localparam int unsigned OP_MSB = 31;
  localparam int unsigned OP_LSB = 26;
  localparam int unsigned RS_MSB = 25;
  localparam int unsigned RS_LSB = 21;
  localparam int unsigned RT_MSB = 20;
  localparam int unsigned RT_LSB = 16;
  localparam int unsigned RD_MSB = 15;
  localparam int unsigned RD_LSB = 11;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage1_if_id_reg.sv
// IF/ID pipeline register.
//   clk, rst          : clock, synchronous active-high reset
//   load              : capture d_instr/d_pc as a valid instruction
//   flush             : insert a bubble (wins over load)
//   d_instr, d_pc     : incoming instruction word and its PC
//   valid, instr, pc, pc_plus4 : registered IF/ID contents
// With neither load nor flush asserted the register holds.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_pc,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid    <= 1'b0;
      instr    <= NOP_WORD;
      pc       <= '0;
      pc_plus4 <= '0;
    end else if (load) begin
      valid    <= 1'b1;
      instr    <= d_instr;
      pc       <= d_pc;
      pc_plus4 <= d_pc + 32'd4;
    end
  end

endmodule

// File: rtl/fetch_stage1.sv
// Stage-1 instruction fetch with IF/ID register and stage-2 address decode.
//   clk, rst                  : clock, synchronous active-high reset
//   imem_req/imem_addr        : one-outstanding fetch request to instruction memory
//   imem_rvalid/imem_rdata    : fetch response (may arrive in the request cycle)
//   stall                     : hazard-unit hold of PC and IF/ID
//   redirect/redirect_pc      : taken branch/jump; flushes and reloads the PC
//   id_valid/id_instr/id_pc/id_pc_plus4 : IF/ID contents
//   rs_addr/rt_addr/wd_addr/r_enable    : register-file decode from IF/ID
module fetch_stage1
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic [4:0]  wd_addr,
  output logic        r_enable
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drop_addr_q, drop_addr_d;
  logic [31:0]  skid_instr_q, skid_instr_d;
  logic [31:0]  skid_pc_q, skid_pc_d;

  logic         id_load, id_flush;
  logic [31:0]  id_src_instr, id_src_pc;
  logic [31:0]  pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  // State register: FSM state, PC, stale drop address and skid buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      drop_addr_q  <= RESET_PC;
      skid_instr_q <= NOP_WORD;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_addr_q  <= drop_addr_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  // Next-state logic. Redirect is checked first in every state.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_addr_d  = drop_addr_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    id_load      = 1'b0;
    id_flush     = 1'b0;
    id_src_instr = imem_rdata;
    id_src_pc    = pc_q;

    case (state_q)
      FETCH: begin
        if (redirect) begin
          pc_d     = redirect_pc;
          id_flush = 1'b1;
          // Request still in flight: keep presenting the old address until
          // its response is consumed and thrown away.
          if (!imem_rvalid) begin
            drop_addr_d = pc_q;
            state_d     = DROP;
          end
        end else if (imem_rvalid) begin
          pc_d = pc_plus4;
          if (stall) begin
            skid_instr_d = imem_rdata;
            skid_pc_d    = pc_q;
            state_d      = HOLD;
          end else begin
            id_load = 1'b1;
          end
        end else if (!stall) begin
          id_flush = 1'b1;
        end
      end

      HOLD: begin
        if (redirect) begin
          skid_instr_d = NOP_WORD;
          skid_pc_d    = '0;
          pc_d         = redirect_pc;
          id_flush     = 1'b1;
          state_d      = FETCH;
        end else if (!stall) begin
          id_load      = 1'b1;
          id_src_instr = skid_instr_q;
          id_src_pc    = skid_pc_q;
          state_d      = FETCH;
        end
      end

      DROP: begin
        id_flush = 1'b1;
        if (redirect) begin
          pc_d = redirect_pc;
        end
        if (imem_rvalid) begin
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Memory request outputs.
  always_comb begin
    imem_req  = !rst && (state_q != HOLD);
    imem_addr = (state_q == DROP) ? drop_addr_q : pc_q;
  end

  if_id_reg #(
    .NOP_WORD (NOP_WORD)
  ) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .load     (id_load),
    .flush    (id_flush),
    .d_instr  (id_src_instr),
    .d_pc     (id_src_pc),
    .valid    (id_valid),
    .instr    (id_instr),
    .pc       (id_pc),
    .pc_plus4 (id_pc_plus4)
  );

  // Decode is taken from IF/ID only; a bubble holds NOP_WORD.
  assign rs_addr  = id_instr[RS_MSB:RS_LSB];
  assign rt_addr  = id_instr[RT_MSB:RT_LSB];
  assign wd_addr  = (id_instr[OP_MSB:OP_LSB] == OP_RTYPE) ? id_instr[RD_MSB:RD_LSB]
                                                           : id_instr[RT_MSB:RT_LSB];
  assign r_enable = id_valid;

endmodule
